// File: rtl/ioctl_dip_sender.sv
// Replays a DIP-switch image as an hps_io-style ioctl download burst at INDEX,
// one byte strobe per WRITE, separated by GAP idle cycles.
module ioctl_dip_sender #(
  parameter int unsigned NBYTES = 8,
  parameter int unsigned GAP    = 4,
  parameter int unsigned INDEX  = 254
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   dip_data,
  input  logic                  ioctl_wait,
  output logic                  busy,
  output logic                  done,
  output logic                  ioctl_download,
  output logic [15:0]           ioctl_index,
  output logic                  ioctl_wr,
  output logic [26:0]           ioctl_addr,
  output logic [7:0]            ioctl_dout
);

  localparam int unsigned AW = $clog2(NBYTES) + 1;
  localparam int unsigned GW = $clog2(GAP + 1);
  localparam logic [AW-1:0] LastAddr = AW'(NBYTES - 1);
  localparam logic [GW-1:0] GapLast  = GW'(GAP - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StWrite,
    StGap,
    StFinish
  } state_e;

  state_e                state_q;
  logic [AW-1:0]         addr_q;
  logic [GW-1:0]         gap_q;
  logic [8*NBYTES-1:0]   dip_q;
  logic [8*NBYTES-1:0]   dip_next;

  // The latched image is shifted down so the next byte is always in the low lane.
  assign dip_next   = dip_q >> 8;
  assign ioctl_addr = 27'(addr_q);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q        <= StIdle;
      addr_q         <= '0;
      gap_q          <= '0;
      dip_q          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      ioctl_download <= 1'b0;
      ioctl_index    <= '0;
      ioctl_wr       <= 1'b0;
      ioctl_dout     <= '0;
    end else begin
      done     <= 1'b0;
      ioctl_wr <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q        <= StSetup;
            dip_q          <= dip_data;
            busy           <= 1'b1;
            ioctl_download <= 1'b1;
            ioctl_index    <= 16'(INDEX);
            addr_q         <= '0;
            ioctl_dout     <= dip_data[7:0];
          end
        end
        StSetup: begin
          if (!ioctl_wait) begin
            state_q  <= StWrite;
            ioctl_wr <= 1'b1;
          end
        end
        StWrite: begin
          if (addr_q == LastAddr) begin
            state_q <= StFinish;
          end else begin
            state_q    <= StGap;
            gap_q      <= '0;
            addr_q     <= addr_q + 1'b1;
            dip_q      <= dip_next;
            ioctl_dout <= dip_next[7:0];
          end
        end
        StGap: begin
          // Counter saturates at GapLast while the receiver stalls.
          if (gap_q == GapLast) begin
            if (!ioctl_wait) begin
              state_q  <= StWrite;
              ioctl_wr <= 1'b1;
            end
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        StFinish: begin
          state_q        <= StIdle;
          done           <= 1'b1;
          busy           <= 1'b0;
          ioctl_download <= 1'b0;
          ioctl_index    <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/ioctl_dip_sender.md
Name: ioctl_dip_sender

Overview:
- Transmitter side of the HPS ioctl download interface: emits a DIP-switch image as a burst of ioctl byte writes at index 254.
- Output stream is identical to what hps_io produces, so the core's DIP loader (dipsw[] capture on ioctl_wr at index 254, addr[24:3]==0) is driven without the HPS.
- Uses: power-on default DIP injection, and stimulus source in simulation benches.

Parameters:
- NBYTES, 8, number of bytes sent per burst (1..8).
- GAP, 4, idle cycles between consecutive write strobes (>=1).
- INDEX, 254, value driven on ioctl_index during a burst.

Ports:
- clk_sys  in  1  system clock (57.272 MHz); all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a burst; sampled only in IDLE.
- dip_data  in  8*NBYTES  image; byte k = bits [8k+7:8k]; latched on accepted start.
- ioctl_wait  in  1  receiver stall; while high, no new write strobe is issued.
- busy  out  1  high from accepted start until the done cycle (exclusive).
- done  out  1  one-cycle pulse when a burst completes.
- ioctl_download  out  1  burst-in-progress flag.
- ioctl_index  out  16  INDEX while ioctl_download=1, else 0.
- ioctl_wr  out  1  one-cycle write strobe per byte.
- ioctl_addr  out  27  byte address, zero-extended byte counter.
- ioctl_dout  out  8  byte being written.

Behaviour:
- One clock, clk_sys. reset is synchronous and active-high.
- Reset values: busy=0, done=0, ioctl_download=0, ioctl_index=0, ioctl_wr=0, ioctl_addr=0, ioctl_dout=0. State goes to IDLE and the byte counter to 0.
- A reset asserted mid-burst aborts it. All outputs take their reset values at the next edge, and done is not pulsed.
- FSM states: IDLE, SETUP, WRITE, GAP, FINISH.
- IDLE -> SETUP: on start=1. dip_data is latched; busy=1, ioctl_download=1, ioctl_index=INDEX, ioctl_addr=0, ioctl_dout=byte0.
- SETUP -> WRITE: when ioctl_wait=0; otherwise stay in SETUP.
- WRITE: ioctl_wr=1 for exactly one cycle. ioctl_addr and ioctl_dout are stable during the strobe.
  - If k < NBYTES-1: go to GAP. On the WRITE->GAP edge, addr becomes k+1 and dout becomes byte k+1.
  - If k = NBYTES-1: go to FINISH.
- GAP: counts GAP cycles with ioctl_wr=0. When the count expires:
  - ioctl_wait=0: go to WRITE.
  - ioctl_wait=1: hold in GAP with the counter saturated until wait drops, then go to WRITE on the next edge.
- Nominal strobe timing (no wait, start accepted at edge 0): strobe k is high in the cycle after edge 1+k*(GAP+1).
- FINISH: one cycle, with ioctl_download=1 and ioctl_wr=0.
- FINISH -> IDLE: on this edge, done=1 for one cycle. At the same edge busy, ioctl_download and ioctl_index go to 0.
  - ioctl_addr and ioctl_dout hold their last values until the next start.
- start during busy (SETUP..FINISH) is ignored. start held high continuously gives back-to-back bursts, with one IDLE cycle (the done cycle) between them.
- start and reset in the same cycle: reset wins.
- ioctl_wait is ignored in WRITE and FINISH. A strobe already issued is never extended or repeated.
- Address counter width: $clog2(NBYTES)+1 bits, zero-extended to 27. ioctl_addr[24:3] is always 0 for NBYTES<=8.
- Burst length without wait: 1 (SETUP) + NBYTES (WRITE) + (NBYTES-1)*GAP (GAP) + 1 (FINISH) cycles.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0, busy=0, no ioctl_wr.
- NBYTES=8, GAP=4, dip_data=64'h0807060504030201, start pulse at edge 0 ->
  - exactly 8 strobes, on the cycles after edges 1,6,11,...,36;
  - strobe k carries addr=k, dout=k+1, ioctl_index=254;
  - done pulse 2 cycles after the last strobe; busy high for 38 cycles.
- Loopback into the core's dipsw[] capture logic with dip_data byte0=8'h1F -> sw=8'h1F after done, i.e. COINAGE=1, PLAYTIME=4'hF.
- ioctl_wait held high for 7 cycles starting in the GAP after strobe 2 -> strobe 3 delayed by exactly the stall overrun; all 8 bytes delivered in order, none duplicated.
- Reset asserted for one cycle right after strobe 4 -> ioctl_download=0 at the next edge, no further strobes, no done. A following start re-sends from addr 0.
- start pulsed again at strobe 3 of a burst -> ignored (exactly 8 strobes, one done). start held high -> second burst's SETUP begins on the edge after the done cycle.
